serial_mult_arbiter: RTL

SERIAL_MULT_ARBITER -- requirements
Module: serial_mult_arbiter

---
 rtl/serial_mult_pkg.sv | 16 +
 rtl/serial_mult_arbiter_rr.sv | 33 +++
 rtl/serial_mult_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_mult_pkg.sv
// Shared definitions for the serial multiplier arbiter: FSM state encoding
// and the default operand width / requester count.
package serial_mult_pkg;

    localparam int WL_DEFAULT   = 4;
    localparam int NREQ_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        RESP
    } state_e;

endpackage

// File: rtl/serial_mult_arbiter_rr.sv
// Round-robin grant selection: searches upward from the requester after
// last_grant and returns the first active request as one-hot plus index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    // Walk from the farthest candidate to the nearest so the nearest active
    // requester overwrites any earlier match.
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = int'(last_grant) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[IW'(cand)]) begin
                grant            = '0;
                grant[IW'(cand)] = 1'b1;
                grant_idx        = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/serial_mult_arbiter.sv
// Shares one external shift-add multiplier among NREQ requesters: grants
// round-robin, drives a LOAD strobe, waits WL cycles, then holds the product.
module serial_mult_arbiter
    import serial_mult_pkg::*;
#(
    parameter int WL   = WL_DEFAULT,
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*WL-1:0] req_a,
    input  logic [NREQ*WL-1:0] req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [2*WL-1:0]    rsp_data,
    output logic               mul_load,
    output logic [2*WL-1:0]    mul_a,
    output logic [2*WL-1:0]    mul_b,
    input  logic [2*WL-1:0]    mul_result,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WL > 1) ? $clog2(WL) : 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [2*WL-1:0]   mul_a_q, mul_a_d;
    logic [2*WL-1:0]   mul_b_q, mul_b_d;
    logic              mul_load_q, mul_load_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*WL-1:0]   rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_load_d   = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = LOAD;
                    owner_d    = arb_idx;
                    mul_a_d    = {{WL{1'b0}}, req_a[arb_idx*WL +: WL]};
                    mul_b_d    = {{WL{1'b0}}, req_b[arb_idx*WL +: WL]};
                    mul_load_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WL - 1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_data_d           = mul_result;
                rsp_valid_d          = '0;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                // Only the owning requester's ready completes the handshake.
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d  = '0;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= '0;
            last_grant_q <= IW'(NREQ - 1);
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_load_q   <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_load_q   <= mul_load_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // The accept pulse is combinational so a grant is possible in the very
    // first IDLE cycle; it is masked while reset is held.
    assign req_ready = (state_q == IDLE && RST) ? arb_grant : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mul_load  = mul_load_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = (state_q != IDLE);

endmodule
